// File: rtl/q2_panel_ctl_if.sv
// rtl/q2_panel_ctl_if.sv - memory bus between the panel/CPU owner mux and memory
interface q2_panel_ctl_if;
    logic [11:0] mem_abus;
    logic [11:0] mem_dout;
    logic        mem_dout_oe;
    logic        mem_rdm;
    logic        mem_wrm;
    logic [11:0] mem_din;

    modport master (
        output mem_abus,
        output mem_dout,
        output mem_dout_oe,
        output mem_rdm,
        output mem_wrm,
        input  mem_din
    );

    modport slave (
        input  mem_abus,
        input  mem_dout,
        input  mem_dout_oe,
        input  mem_rdm,
        input  mem_wrm,
        output mem_din
    );
endinterface

// File: rtl/q2_panel_ctl.sv
// rtl/q2_panel_ctl.sv - q2 front panel: switch debounce, load/deposit/examine, run control, bus owner mux
module q2_panel_ctl #(
    parameter int DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw,
    input  logic        ld_sw,
    input  logic        dep_sw,
    input  logic        exa_sw,
    input  logic        start_sw,
    input  logic        stop_sw,
    input  logic        cpu_idle,
    input  logic [11:0] cpu_abus,
    input  logic [11:0] cpu_dout,
    input  logic        cpu_rdm,
    input  logic        cpu_wrm,
    output logic [11:0] cpu_din,
    output logic        run,
    output logic        cpu_start,
    output logic [11:0] start_pc,
    output logic [11:0] addr,
    output logic [11:0] disp,
    q2_panel_ctl_if.master mem_bus
);

    typedef enum logic [2:0] {
        S_HALT,
        S_DEP_SETUP,
        S_DEP_STROBE,
        S_DEP_HOLD,
        S_EXA_READ,
        S_RUN,
        S_STOPPING
    } state_t;

    // Switch index order doubles as event priority: 0 is the highest.
    localparam int N_SW = 5;
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

    logic [N_SW-1:0] raw;
    logic [N_SW-1:0] sync1;
    logic [N_SW-1:0] sync2;
    logic [N_SW-1:0] lvl;
    logic [N_SW-1:0] lvl_d;
    logic [N_SW-1:0] ev;
    logic [7:0]      cnt [N_SW];

    state_t      state, state_n;
    logic [11:0] addr_n, disp_n, wdata, wdata_n;
    logic        cpu_start_n;

    assign raw = {exa_sw, dep_sw, ld_sw, start_sw, stop_sw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            ev    <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_d <= lvl;
            ev    <= lvl & ~lvl_d;
            for (int i = 0; i < N_SW; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        lvl[i] <= ~lvl[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HALT;
            addr      <= '0;
            disp      <= '0;
            wdata     <= '0;
            cpu_start <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            disp      <= disp_n;
            wdata     <= wdata_n;
            cpu_start <= cpu_start_n;
        end
    end

    // The HALT if/else chain is the priority encoder; losing events are simply dropped.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        disp_n      = disp;
        wdata_n     = wdata;
        cpu_start_n = 1'b0;
        case (state)
            S_HALT: begin
                if (ev[0]) begin
                    state_n = S_HALT;
                end else if (ev[1]) begin
                    cpu_start_n = 1'b1;
                    state_n     = S_RUN;
                end else if (ev[2]) begin
                    addr_n = sw;
                end else if (ev[3]) begin
                    wdata_n = sw;
                    disp_n  = sw;
                    state_n = S_DEP_SETUP;
                end else if (ev[4]) begin
                    state_n = S_EXA_READ;
                end
            end
            S_DEP_SETUP:  state_n = S_DEP_STROBE;
            S_DEP_STROBE: state_n = S_DEP_HOLD;
            S_DEP_HOLD: begin
                addr_n  = addr + 12'd1;
                state_n = S_HALT;
            end
            S_EXA_READ: begin
                disp_n  = mem_bus.mem_din;
                addr_n  = addr + 12'd1;
                state_n = S_HALT;
            end
            S_RUN: begin
                if (ev[0]) begin
                    state_n = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (cpu_idle) begin
                    state_n = S_HALT;
                end
            end
            default: state_n = S_HALT;
        endcase
    end

    // CPU keeps the bus through STOPPING so an in-flight memory cycle can complete.
    always_comb begin
        mem_bus.mem_abus    = addr;
        mem_bus.mem_dout    = '0;
        mem_bus.mem_dout_oe = 1'b0;
        mem_bus.mem_rdm     = 1'b0;
        mem_bus.mem_wrm     = 1'b0;
        case (state)
            S_RUN, S_STOPPING: begin
                mem_bus.mem_abus    = cpu_abus;
                mem_bus.mem_dout    = cpu_dout;
                mem_bus.mem_dout_oe = cpu_wrm;
                mem_bus.mem_rdm     = cpu_rdm;
                mem_bus.mem_wrm     = cpu_wrm;
            end
            S_DEP_SETUP, S_DEP_HOLD: begin
                mem_bus.mem_dout    = wdata;
                mem_bus.mem_dout_oe = 1'b1;
            end
            S_DEP_STROBE: begin
                mem_bus.mem_dout    = wdata;
                mem_bus.mem_dout_oe = 1'b1;
                mem_bus.mem_wrm     = 1'b1;
            end
            S_EXA_READ: begin
                mem_bus.mem_rdm = 1'b1;
            end
            default: begin
                mem_bus.mem_abus = addr;
            end
        endcase
    end

    assign run      = (state == S_RUN);
    assign start_pc = addr;
    assign cpu_din  = mem_bus.mem_din;

endmodule

// File: tb/tb_q2_panel_ctl.sv
// tb/tb_q2_panel_ctl.sv - self-checking bench for q2_panel_ctl with a cycle model and directed panel sequences
module tb_q2_panel_ctl;
    localparam int DB = 4;

    typedef enum int {M_HALT, M_DSET, M_DSTB, M_DHLD, M_EXA, M_RUN, M_STOP} mstate_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  sws;
    logic [11:0] sw, cpu_abus, cpu_dout;
    logic        cpu_rdm, cpu_wrm, cpu_idle;
    logic [11:0] cpu_din, start_pc, addr, disp;
    logic        run, cpu_start;

    logic [11:0] tmem [4096];
    logic [11:0] mmem [4096];

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [11:0] wr_addr = '0, wr_data = '0;
    int start_pulses = 0;
    logic [11:0] start_pc_seen = '0;

    mstate_t     m_st = M_HALT;
    logic [11:0] m_addr = '0, m_disp = '0, m_wdata = '0;
    logic        m_start = 1'b0;
    logic [4:0]  m_lvl = '0, rise1 = '0, rise2 = '0;
    logic [15:0] hist [5];

    always #5 clk = ~clk;

    q2_panel_ctl_if bus ();
    assign bus.mem_din = tmem[bus.mem_abus];

    q2_panel_ctl #(.DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .ld_sw(sws[2]), .dep_sw(sws[3]), .exa_sw(sws[4]),
        .start_sw(sws[1]), .stop_sw(sws[0]),
        .cpu_idle(cpu_idle), .cpu_abus(cpu_abus), .cpu_dout(cpu_dout),
        .cpu_rdm(cpu_rdm), .cpu_wrm(cpu_wrm), .cpu_din(cpu_din),
        .run(run), .cpu_start(cpu_start), .start_pc(start_pc),
        .addr(addr), .disp(disp), .mem_bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: a level flips once the last DB synchronised samples all disagree
    // with it; the highest-priority rising event acts two edges after the flip.
    task automatic model_step();
        logic [4:0] act, rise;
        logic       differ;
        int         win;
        if (m_st == M_DSTB) mmem[m_addr] = m_wdata;
        if (rst) begin
            m_st = M_HALT; m_addr = '0; m_disp = '0; m_wdata = '0; m_start = 1'b0;
            m_lvl = '0; rise1 = '0; rise2 = '0;
            for (int i = 0; i < 5; i++) hist[i] = '0;
        end else begin
            act = rise2;
            for (int i = 0; i < 5; i++) begin
                differ = 1'b1;
                for (int k = 1; k <= DB; k++) if (hist[i][k] == m_lvl[i]) differ = 1'b0;
                rise[i] = differ && !m_lvl[i];
                if (differ) m_lvl[i] = ~m_lvl[i];
                hist[i] = {hist[i][14:0], sws[i]};
            end
            rise2 = rise1;
            rise1 = rise;
            win = -1;
            for (int k = 0; k < 5; k++) if (act[k] && win < 0) win = k;
            m_start = 1'b0;
            case (m_st)
                M_HALT: case (win)
                    1: begin m_start = 1'b1; m_st = M_RUN; end
                    2: m_addr = sw;
                    3: begin m_wdata = sw; m_disp = sw; m_st = M_DSET; end
                    4: m_st = M_EXA;
                    default: ;
                endcase
                M_DSET: m_st = M_DSTB;
                M_DSTB: m_st = M_DHLD;
                M_DHLD: begin m_addr = m_addr + 12'd1; m_st = M_HALT; end
                M_EXA:  begin m_disp = mmem[m_addr]; m_addr = m_addr + 12'd1; m_st = M_HALT; end
                M_RUN:  if (win == 0) m_st = M_STOP;
                M_STOP: if (cpu_idle) m_st = M_HALT;
                default: m_st = M_HALT;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [11:0] e_abus, e_dout;
        logic        e_oe, e_rdm, e_wrm;
        e_abus = m_addr; e_dout = '0; e_oe = 1'b0; e_rdm = 1'b0; e_wrm = 1'b0;
        if (m_st == M_RUN || m_st == M_STOP) begin
            e_abus = cpu_abus; e_dout = cpu_dout; e_oe = cpu_wrm; e_rdm = cpu_rdm; e_wrm = cpu_wrm;
        end else if (m_st == M_DSET || m_st == M_DSTB || m_st == M_DHLD) begin
            e_dout = m_wdata; e_oe = 1'b1; e_wrm = (m_st == M_DSTB);
        end else if (m_st == M_EXA) begin
            e_rdm = 1'b1;
        end
        chk("run", 32'(run), 32'(m_st == M_RUN));
        chk("cpu_start", 32'(cpu_start), 32'(m_start));
        chk("addr", 32'(addr), 32'(m_addr));
        chk("disp", 32'(disp), 32'(m_disp));
        chk("start_pc", 32'(start_pc), 32'(m_addr));
        chk("mem_abus", 32'(bus.mem_abus), 32'(e_abus));
        chk("mem_dout", 32'(bus.mem_dout), 32'(e_dout));
        chk("mem_dout_oe", 32'(bus.mem_dout_oe), 32'(e_oe));
        chk("mem_rdm", 32'(bus.mem_rdm), 32'(e_rdm));
        chk("mem_wrm", 32'(bus.mem_wrm), 32'(e_wrm));
        chk("cpu_din", 32'(cpu_din), 32'(bus.mem_din));
        if (cpu_start === 1'b1) begin
            start_pulses++;
            start_pc_seen = start_pc;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #3;
        compare_all();
    end

    // Memory: the write lands mid-cycle of the strobe.
    initial begin
        for (int i = 0; i < 4096; i++) begin
            tmem[i] = '0;
            mmem[i] = '0;
        end
        tmem[12'h345] = 12'h6A7;
        mmem[12'h345] = 12'h6A7;
        forever begin
            @(negedge clk);
            if (bus.mem_wrm === 1'b1) begin
                tmem[bus.mem_abus] = bus.mem_dout;
                wr_count++;
                wr_addr = bus.mem_abus;
                wr_data = bus.mem_dout;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic press(input int idx);
        sws[idx] = 1'b1;
        repeat (DB + 4) @(negedge clk);
        sws[idx] = 1'b0;
        repeat (DB + 8) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sws = '0; sw = '0;
        cpu_abus = '0; cpu_dout = '0; cpu_rdm = 1'b0; cpu_wrm = 1'b0; cpu_idle = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_run", 32'(run), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_mem_wrm", 32'(bus.mem_wrm), 0);
        chk("rst_mem_abus", 32'(bus.mem_abus), 0);
        rst = 1'b0;

        sws[3] = 1'b1;
        repeat (DB - 1) @(negedge clk);
        sws[3] = 1'b0;
        repeat (DB + 10) @(negedge clk);
        chk("glitch_no_write", 32'(wr_count), 0);
        chk("glitch_addr", 32'(addr), 0);

        sw = 12'h123; press(2);
        sw = 12'hABC; press(3);
        chk("dep_wr_count", 32'(wr_count), 1);
        chk("dep_wr_addr", 32'(wr_addr), 'h123);
        chk("dep_wr_data", 32'(wr_data), 'hABC);
        chk("dep_addr_inc", 32'(addr), 'h124);
        chk("dep_disp", 32'(disp), 'hABC);
        chk("model_addr_pin", 32'(m_addr), 'h124);

        sw = 12'hFFF; press(2);
        sw = 12'h555; press(3);
        chk("wrap_wr_addr", 32'(wr_addr), 'hFFF);
        chk("wrap_wr_data", 32'(wr_data), 'h555);
        chk("wrap_addr", 32'(addr), 0);
        sw = 12'hFFF; press(2);
        press(4);
        chk("exa_disp", 32'(disp), 'h555);
        chk("exa_addr", 32'(addr), 0);
        chk("model_disp_pin", 32'(m_disp), 'h555);

        sw = 12'h200; press(2);
        press(1);
        chk("start_pulses", 32'(start_pulses), 1);
        chk("start_pc_seen", 32'(start_pc_seen), 'h200);
        chk("start_run", 32'(run), 1);
        cpu_abus = 12'h345; cpu_rdm = 1'b1;
        @(negedge clk);
        chk("cpu_read_din", 32'(cpu_din), 'h6A7);
        chk("cpu_read_abus", 32'(bus.mem_abus), 'h345);
        chk("cpu_read_rdm", 32'(bus.mem_rdm), 1);
        cpu_rdm = 1'b0;
        sw = 12'h0F0; press(3);
        chk("run_dep_ignored", 32'(wr_count), 2);
        chk("run_still", 32'(run), 1);

        cpu_idle = 1'b0;
        sws[0] = 1'b1;
        for (int i = 0; i < 40 && run !== 1'b0; i++) @(negedge clk);
        chk("stop_run_fell", 32'(run), 0);
        sws[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stopping_cpu_bus", 32'(bus.mem_abus), 'h345);
        end
        cpu_idle = 1'b1;
        @(negedge clk);
        chk("stop_panel_bus", 32'(bus.mem_abus), 'h200);
        repeat (DB + 8) @(negedge clk);

        sws = 5'b00011;
        repeat (DB + 4) @(negedge clk);
        sws = '0;
        repeat (DB + 8) @(negedge clk);
        chk("stop_beats_start_run", 32'(run), 0);
        chk("stop_beats_start_pulse", 32'(start_pulses), 1);

        sw = 12'h777;
        sws[3] = 1'b1;
        for (int i = 0; i < 40 && bus.mem_wrm !== 1'b1; i++) @(negedge clk);
        chk("strobe_reached", 32'(bus.mem_wrm), 1);
        rst = 1'b1;
        sws[3] = 1'b0;
        @(negedge clk);
        chk("rst_strobe_wrm", 32'(bus.mem_wrm), 0);
        chk("rst_strobe_addr", 32'(addr), 0);
        chk("rst_strobe_oe", 32'(bus.mem_dout_oe), 0);
        rst = 1'b0;
        repeat (DB + 8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/q2_panel_ctl.md
# q2_panel_ctl

Front-panel controller for the q2 12-bit machine. It debounces and edge-detects the panel switches, runs the load-address, deposit and examine sequences against memory while the CPU is halted, and sequences start and stop with the CPU. It is also the single memory-bus owner mux: the CPU drives memory only while it is granted the bus, and the panel drives it otherwise.

## Interface
Parameters:
- `DEBOUNCE`, default 16: number of consecutive stable samples a synchronized switch needs before a level change is accepted; range 1–255.

Ports:
- `clk  in  1`  system clock; all state changes on its rising edge.
- `rst  in  1`  reset, synchronous and active-high.
- `sw  in  12`  data/address switches; sampled raw, not debounced.
- `ld_sw`, `dep_sw`, `exa_sw`, `start_sw`, `stop_sw`  in  1 each  momentary panel switches, asynchronous and bouncy.
- `cpu_idle  in  1`  CPU is at an instruction boundary with no memory cycle in flight.
- `cpu_abus  in  12`, `cpu_dout  in  12`, `cpu_rdm  in  1`, `cpu_wrm  in  1`  CPU memory request.
- `cpu_din  out  12`  memory read data to the CPU; equals `mem_din` at all times.
- `run  out  1`  CPU enable and bus grant to the CPU.
- `cpu_start  out  1`  one-cycle pulse that loads the CPU PC from `start_pc`.
- `start_pc  out  12`  equals `addr`.
- `addr  out  12`  panel address register, shown on the panel lamps.
- `disp  out  12`  last examined or deposited word, shown on the panel lamps.
- `mem_abus  out  12`, `mem_dout  out  12`, `mem_dout_oe  out  1`, `mem_rdm  out  1`, `mem_wrm  out  1`  memory bus outputs.
- `mem_din  in  12`  memory read data; combinational while `mem_rdm` is high.

## Operation
- Each switch passes through a 2-flop synchronizer, then a per-switch counter. The debounced level flips only after `DEBOUNCE` consecutive samples differ from the current level. A debounced 0→1 transition is the switch's event, and it lasts one cycle.
- Event priority when several fire in the same cycle: stop > start > ld > dep > exa. Lower-priority events in that cycle are dropped, not queued.
- States: HALT, DEP_SETUP, DEP_STROBE, DEP_HOLD, EXA_READ, RUN, STOPPING.
- HALT:
  - ld event: `addr` ← `sw`. Stays in HALT.
  - dep event: latch `sw` into the write-data register and `disp`, then go to DEP_SETUP.
  - exa event: go to EXA_READ.
  - start event: assert `cpu_start` for one cycle, set `run`=1, go to RUN.
  - stop event: no effect.
- DEP_SETUP: drive `mem_abus`=`addr`, `mem_dout`=write data, `mem_dout_oe`=1. Go to DEP_STROBE.
- DEP_STROBE: same drive plus `mem_wrm`=1. Go to DEP_HOLD.
- DEP_HOLD: same drive with `mem_wrm`=0. Then `addr` ← `addr`+1 and go to HALT.
- EXA_READ: `mem_abus`=`addr`, `mem_rdm`=1. At the end of the cycle, `disp` ← `mem_din` and `addr` ← `addr`+1. Go to HALT.
- Address arithmetic is modulo 4096: 0xFFF+1 = 0x000.
- RUN: all mem outputs are a straight mux of the cpu_* inputs, with `mem_dout_oe`=`cpu_wrm`. ld, dep, exa and start events are ignored. A stop event sets `run`=0 and moves to STOPPING.
- STOPPING: the CPU keeps the bus so it can finish its current memory cycle, but `run`=0 so it fetches nothing new. When `cpu_idle`=1, go to HALT and the panel takes the bus. A start event in STOPPING is ignored.
- Events that arrive during DEP_*, EXA_READ or STOPPING are dropped, including stop.
- Whenever the panel owns the bus and is not in a DEP/EXA state, `mem_rdm`=`mem_wrm`=`mem_dout_oe`=0 and `mem_abus`=`addr`.

## Timing
- Reset values: `run`=0, `cpu_start`=0, `addr`=0, `disp`=0, `start_pc`=0, `mem_abus`=0, `mem_dout`=0, `mem_dout_oe`=0, `mem_rdm`=0, `mem_wrm`=0. State is HALT, synchronizers and debounced levels are 0, and debounce counters are 0.
- Reset mid-sequence aborts immediately. `mem_wrm` is low in the first cycle after `rst` is sampled high, even during DEP_STROBE.
- Switch latency: a clean 0→1 edge produces its event exactly 2+`DEBOUNCE` cycles after the first sampling edge that sees it. A pulse or bounce shorter than `DEBOUNCE` stable samples produces no event.
- Deposit: 3 cycles after the event cycle. `mem_wrm` is high for exactly one cycle. Address and data are stable one cycle before and one cycle after that strobe. `addr` increments at the end of DEP_HOLD.
- Examine: 1 cycle. `disp` and `addr` update on the same edge.
- Start: `cpu_start` and the `run` rise occur on the same edge, one cycle after the event. `start_pc` holds the pre-start `addr`.
- Stop: `run` falls one cycle after the event. The bus returns to the panel on the edge after the first cycle in STOPPING with `cpu_idle`=1. If `cpu_idle` is already 1, that is 1 cycle after the stop edge.
- Bus ownership never changes while `mem_wrm` or `mem_rdm` is high.

## Test plan
- Reset, `DEBOUNCE`=4: all outputs take their listed reset values. A 3-cycle glitch on `dep_sw` → no write, `addr` stays 0.
- Set `sw`=0x123 and pulse `ld_sw`; then set `sw`=0xABC and pulse `dep_sw` → exactly one `mem_wrm` cycle with `mem_abus`=0x123 and `mem_dout`=0xABC; afterwards `addr`=0x124 and `disp`=0xABC.
- Load 0xFFF, then deposit 0x555 → write lands at 0xFFF and `addr` wraps to 0x000. Load 0xFFF again and examine → `disp`=0x555 and `addr`=0x000.
- Load 0x200 and pulse `start_sw` → one `cpu_start` pulse with `start_pc`=0x200 and `run`=1. CPU reads pass through to `mem_*` and `cpu_din`. A `dep_sw` press during RUN causes no write.
- While running, hold `cpu_idle`=0 for 5 cycles and pulse `stop_sw` → `run` falls, the CPU keeps the bus for those 5 cycles, and the panel takes the bus on the edge after `cpu_idle` rises.
- In HALT, make `start_sw` and `stop_sw` fire in the same cycle → the stop wins, so the start is dropped and `run` stays 0. Separately, assert `rst` during DEP_STROBE → `mem_wrm` is 0 on the next cycle and `addr`=0.
